// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl_pkg
//  Purpose  : Shared definitions for the EX-stage mul/div sequencer:
//             op_i encodings, FSM state type and small op-decode helpers.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_ctrl_pkg;

    // op_i encodings
    localparam logic [2:0] MULDIV_NONE  = 3'b000;
    localparam logic [2:0] MULDIV_MULT  = 3'b001;
    localparam logic [2:0] MULDIV_MULTU = 3'b010;
    localparam logic [2:0] MULDIV_DIV   = 3'b011;
    localparam logic [2:0] MULDIV_DIVU  = 3'b100;

    // Width of the multiply latency down-counter (MUL_LATENCY up to 15)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } muldiv_state_t;

    // True for the four real operations; NONE and 101..111 are ignored.
    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op == MULDIV_MULT) || (op == MULDIV_MULTU) ||
               (op == MULDIV_DIV)  || (op == MULDIV_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MULDIV_MULT) || (op == MULDIV_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl_if
//  Purpose  : Handshake bundle between the sequencer and the two
//             multi-cycle units (iterative divider, pipelined multiplier).
//             Suffixes are relative to the sequencer (master side).
//  Ports    : master - sequencer; slave - divider/multiplier side.
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  div_start_o;
    logic                  div_signed_o;
    logic [DATA_W-1:0]     div_op1_o;
    logic [DATA_W-1:0]     div_op2_o;
    logic                  div_annul_o;
    logic                  div_ready_i;
    logic [2*DATA_W-1:0]   div_result_i;   // {remainder, quotient}
    logic                  mul_start_o;
    logic                  mul_signed_o;
    logic [DATA_W-1:0]     mul_a_o;
    logic [DATA_W-1:0]     mul_b_o;
    logic [2*DATA_W-1:0]   mul_result_i;   // {hi, lo}

    modport master (
        output div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o,
        input  div_ready_i, div_result_i,
        output mul_start_o, mul_signed_o, mul_a_o, mul_b_o,
        input  mul_result_i
    );

    modport slave (
        input  div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o,
        output div_ready_i, div_result_i,
        input  mul_start_o, mul_signed_o, mul_a_o, mul_b_o,
        output mul_result_i
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl_lat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl_lat_cnt
//  Purpose  : Down-counter with load and zero flag, used to time the
//             multiplier pipeline while the sequencer sits in MUL_WAIT.
//  Ports    : clk, rst  - clock / synchronous active-high reset
//             load      - load load_val (has priority over dec)
//             dec       - decrement by one
//             zero      - count is zero
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_ctrl_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : EX-stage sequencer for MULT/MULTU/DIV/DIVU. Accepts one op
//             from IDLE, drives the divider or multiplier handshake, holds
//             stallreq until the result is captured, then issues a single
//             HI/LO write once the pipeline is allowed to advance.
//  Ports    : clk, rst            - clock / synchronous active-high reset
//             stall_i, flush_i    - downstream hold / cancel in-flight op
//             op_valid_i, op_i    - op request and encoding
//             src1_i, src2_i      - rs / rt operands
//             unit                - divider / multiplier handshake (master)
//             stallreq_o          - stall request
//             hilo_we_o, hi_o, lo_o - HI/LO write port
//  Config   : MULDIV_DIV0_BYPASS_EN - divide by zero skips the divider and
//             returns hi=src1, lo=all ones.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                op_valid_i,
    input  logic [2:0]          op_i,
    input  logic [DATA_W-1:0]   src1_i,
    input  logic [DATA_W-1:0]   src2_i,
    muldiv_ctrl_if.master       unit,
    output logic                stallreq_o,
    output logic                hilo_we_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);
    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

    muldiv_state_t     r_state, w_state_next;
    logic [DATA_W-1:0] r_op1, r_op2, r_hi, r_lo;
    logic              r_signed, r_mul_first;

    logic w_accept, w_div0;
    logic w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic w_cap_div, w_cap_mul, w_cap_div0;
    logic w_div_start, w_div_annul, w_mul_start, w_stallreq, w_hilo_we;

    // A request is taken in IDLE regardless of stall_i; flush cancels it.
    assign w_accept = op_valid_i && op_is_muldiv(op_i) && !flush_i;

`ifdef MULDIV_DIV0_BYPASS_EN
    assign w_div0 = op_is_div(op_i) && (src2_i == '0);
`else
    assign w_div0 = 1'b0;
`endif

    muldiv_ctrl_lat_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (C_MUL_LOAD),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_stallreq   = 1'b0;
        w_div_start  = 1'b0;
        w_div_annul  = 1'b0;
        w_mul_start  = 1'b0;
        w_hilo_we    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_cap_div    = 1'b0;
        w_cap_mul    = 1'b0;
        w_cap_div0   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_stallreq = 1'b1;
                    if (op_is_div(op_i)) begin
                        if (w_div0) begin
                            w_cap_div0   = 1'b1;
                            w_state_next = ST_DONE;
                        end else begin
                            w_state_next = ST_DIV_WAIT;
                        end
                    end else begin
                        w_cnt_load   = 1'b1;
                        w_state_next = ST_MUL_WAIT;
                    end
                end
            end
            ST_DIV_WAIT: begin
                w_stallreq = 1'b1;
                // Flush beats a simultaneous ready: abort, nothing captured.
                if (flush_i) begin
                    w_div_annul  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (unit.div_ready_i) begin
                    w_cap_div    = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_div_start  = 1'b1;
                end
            end
            ST_MUL_WAIT: begin
                w_stallreq  = 1'b1;
                w_mul_start = r_mul_first;
                if (flush_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_cnt_zero) begin
                    w_cap_mul    = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_dec    = 1'b1;
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    w_state_next = ST_IDLE;
                end else if (!stall_i) begin
                    // The instruction leaves EX on this edge: write once.
                    w_hilo_we    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op1       <= '0;
            r_op2       <= '0;
            r_signed    <= 1'b0;
            r_mul_first <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_state     <= w_state_next;
            r_mul_first <= w_cnt_load;
            if ((r_state == ST_IDLE) && w_accept) begin
                r_op1    <= src1_i;
                r_op2    <= src2_i;
                r_signed <= op_is_signed(op_i);
            end
            if (w_cap_div) begin
                r_hi <= unit.div_result_i[2*DATA_W-1:DATA_W];
                r_lo <= unit.div_result_i[DATA_W-1:0];
            end else if (w_cap_mul) begin
                r_hi <= unit.mul_result_i[2*DATA_W-1:DATA_W];
                r_lo <= unit.mul_result_i[DATA_W-1:0];
            end else if (w_cap_div0) begin
                r_hi <= src1_i;
                r_lo <= '1;
            end
        end
    end

    assign unit.div_start_o  = w_div_start;
    assign unit.div_annul_o  = w_div_annul;
    assign unit.div_signed_o = r_signed;
    assign unit.div_op1_o    = r_op1;
    assign unit.div_op2_o    = r_op2;
    assign unit.mul_start_o  = w_mul_start;
    assign unit.mul_signed_o = r_signed;
    assign unit.mul_a_o      = r_op1;
    assign unit.mul_b_o      = r_op2;

    assign stallreq_o = w_stallreq;
    assign hilo_we_o  = w_hilo_we;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;
endmodule
`default_nettype wire
